// File: rtl/radix_parser_pkg.sv
// Shared constants and types for the radix stream parser.
//   - ASCII codes for digit ranges and legal field terminators
//   - FSM state encoding
//   - radix select encodings (radix_dec input / latched radix)
package radix_parser_pkg;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_F     = 8'h46;
  localparam logic [7:0] CH_a     = 8'h61;
  localparam logic [7:0] CH_f     = 8'h66;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic RADIX_HEX = 1'b0;
  localparam logic RADIX_DEC = 1'b1;

endpackage

// File: rtl/char_to_digit.sv
// Combinational ASCII character classifier.
//   in_char       : ASCII character (B bits)
//   radix_dec     : 0 = hex (letters a-f / A-F are digits), 1 = decimal
//   is_digit      : character is a digit in the selected radix
//   value         : digit value 0..15 (0 when not a digit)
//   is_legal_term : character is ',', '*', CR or LF
module char_to_digit
  import radix_parser_pkg::*;
#(
  parameter int B = 8
) (
  input  logic [B-1:0] in_char,
  input  logic         radix_dec,
  output logic         is_digit,
  output logic [3:0]   value,
  output logic         is_legal_term
);

  always_comb begin
    is_digit = 1'b0;
    value    = 4'd0;
    if (in_char >= B'(CH_0) && in_char <= B'(CH_9)) begin
      is_digit = 1'b1;
      value    = 4'(in_char - B'(CH_0));
    end else if (radix_dec == RADIX_HEX && in_char >= B'(CH_A) && in_char <= B'(CH_F)) begin
      is_digit = 1'b1;
      value    = 4'(in_char - B'(CH_A) + B'(10));
    end else if (radix_dec == RADIX_HEX && in_char >= B'(CH_a) && in_char <= B'(CH_f)) begin
      is_digit = 1'b1;
      value    = 4'(in_char - B'(CH_a) + B'(10));
    end
  end

  assign is_legal_term = (in_char == B'(CH_COMMA)) || (in_char == B'(CH_STAR)) ||
                         (in_char == B'(CH_CR))    || (in_char == B'(CH_LF));

endmodule

// File: rtl/radix_stream_parser.sv
// Character-serial hex/decimal field parser for the NMEA character stream.
// Accumulates digits into an L*B-bit value; the first non-digit ends the
// field and the result is held until the downstream handshake.
//   clk, rst_n   : clock, async active-low reset
//   flush        : synchronous abort back to IDLE (highest priority)
//   radix_dec    : radix for the next field, latched on its first character
//   in_valid/in_ready/in_char : character input handshake
//   out_valid/out_ready       : result handshake
//   num, digit_count, overflow, bad_char : field result and flags
//
// state | meaning
// IDLE  | waiting for the first character of a field
// ACCUM | at least one digit taken, accumulating
// HOLD  | result presented, waiting for out_ready
module radix_stream_parser
  import radix_parser_pkg::*;
#(
  parameter int B  = 8,
  parameter int L  = 4,
  parameter int CW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           radix_dec,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [B-1:0]   in_char,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [L*B-1:0] num,
  output logic [CW-1:0]  digit_count,
  output logic           overflow,
  output logic           bad_char
);

  localparam int W = L * B;
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          radix_q;

  logic          radix_eff;
  logic          is_digit;
  logic [3:0]    digit_val;
  logic          is_legal_term;
  logic          accept;
  logic [W+3:0]  acc_ext;
  logic [W+3:0]  prod;

  assign in_ready  = (state_q != HOLD) && !flush;
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;

  // The first character of a field is classified with the live radix input;
  // later characters use the radix latched with that first digit.
  assign radix_eff = (state_q == IDLE) ? radix_dec : radix_q;

  char_to_digit #(.B(B)) u_char_to_digit (
    .in_char       (in_char),
    .radix_dec     (radix_eff),
    .is_digit      (is_digit),
    .value         (digit_val),
    .is_legal_term (is_legal_term)
  );

  // Four guard bits hold the carry-out of one step for both x10 and x16.
  assign acc_ext = {4'b0, acc_q};
  assign prod    = ((radix_q == RADIX_DEC) ? ((acc_ext << 3) + (acc_ext << 1))
                                           : (acc_ext << 4))
                 + (W + 4)'(digit_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = is_digit ? ACCUM : HOLD;
        ACCUM:   if (accept && !is_digit) state_d = HOLD;
        HOLD:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      radix_q     <= RADIX_HEX;
      num         <= '0;
      digit_count <= '0;
      overflow    <= 1'b0;
      bad_char    <= 1'b0;
    end else if (flush) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_digit) begin
              acc_q   <= W'(digit_val);
              cnt_q   <= CW'(1);
              ovf_q   <= 1'b0;
              radix_q <= radix_dec;
            end else begin
              num         <= '0;
              digit_count <= '0;
              overflow    <= 1'b0;
              bad_char    <= !is_legal_term;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            if (is_digit) begin
              acc_q <= prod[W-1:0];
              if (prod[W+3:W] != 4'd0) ovf_q <= 1'b1;
              if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
            end else begin
              num         <= acc_q;
              digit_count <= cnt_q;
              overflow    <= ovf_q;
              bad_char    <= !is_legal_term;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end
        end
        default: begin
          acc_q <= '0;
          cnt_q <= '0;
          ovf_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_radix_stream_parser.sv
// Self-checking bench: two parser instances (L=4 and L=1) share one input
// stream; each result is compared with a string-level reference model.
module tb_radix_stream_parser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       radix_dec;
  logic       in_valid;
  logic [7:0] in_char;
  logic       out_ready;

  logic        in_ready_a, out_valid_a, ovf_a, bad_a;
  logic [31:0] num_a;
  logic [7:0]  dc_a;
  logic        in_ready_b, out_valid_b, ovf_b, bad_b;
  logic [7:0]  num_b;
  logic [7:0]  dc_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  radix_stream_parser #(.B(8), .L(4), .CW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .radix_dec(radix_dec),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_char(in_char),
    .out_valid(out_valid_a), .out_ready(out_ready), .num(num_a),
    .digit_count(dc_a), .overflow(ovf_a), .bad_char(bad_a)
  );

  radix_stream_parser #(.B(8), .L(1), .CW(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .radix_dec(radix_dec),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_char(in_char),
    .out_valid(out_valid_b), .out_ready(out_ready), .num(num_b),
    .digit_count(dc_b), .overflow(ovf_b), .bad_char(bad_b)
  );

  typedef struct packed {
    logic [63:0] num32;
    logic [63:0] num8;
    logic [7:0]  cnt;
    logic        ovf32;
    logic        ovf8;
    logic        bad;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int digit_of(input byte c, input bit dec);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (!dec && c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (!dec && c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  // Field value from the characters up to the first terminator. The exact
  // value is clamped well above 2^32 so overflow is simply "value >= 2^W".
  function automatic exp_t model(input string s, input bit dec);
    exp_t   e;
    longint truev = 0;
    longint w32 = 0;
    longint w8 = 0;
    int     cnt = 0;
    longint r = dec ? 10 : 16;
    e = '0;
    for (int i = 0; i < s.len(); i++) begin
      byte c = s[i];
      int  d = digit_of(c, dec);
      if (d < 0) begin
        e.bad = !(c == 8'h2C || c == 8'h2A || c == 8'h0D || c == 8'h0A);
        break;
      end
      truev = truev * r + d;
      if (truev > (64'd1 << 40)) truev = 64'd1 << 40;
      w32 = (w32 * r + d) % (64'd1 << 32);
      w8  = (w8 * r + d) % 256;
      if (cnt < 255) cnt++;
    end
    e.num32 = w32;
    e.num8  = w8;
    e.cnt   = 8'(cnt);
    e.ovf32 = truev >= (64'd1 << 32);
    e.ovf8  = truev >= 256;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_char(input byte c);
    int waited = 0;
    if ($urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      in_char  = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_char  = c;
    #1;
    while (!in_ready_a && waited < 20) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 20) chk("in_ready_timeout", 64'(in_ready_a), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic check_result(input string tag, input exp_t e);
    chk({tag, ".out_valid_a"}, 64'(out_valid_a), 64'd1);
    chk({tag, ".out_valid_b"}, 64'(out_valid_b), 64'd1);
    chk({tag, ".in_ready_a"},  64'(in_ready_a), 64'd0);
    chk({tag, ".num_a"},       64'(num_a), e.num32);
    chk({tag, ".num_b"},       64'(num_b), e.num8);
    chk({tag, ".count_a"},     64'(dc_a), 64'(e.cnt));
    chk({tag, ".count_b"},     64'(dc_b), 64'(e.cnt));
    chk({tag, ".ovf_a"},       64'(ovf_a), 64'(e.ovf32));
    chk({tag, ".ovf_b"},       64'(ovf_b), 64'(e.ovf8));
    chk({tag, ".bad_a"},       64'(bad_a), 64'(e.bad));
    chk({tag, ".bad_b"},       64'(bad_b), 64'(e.bad));
  endtask

  // Sends a whole field (last character is its terminator), checks the
  // result one cycle after the terminator, stalls for hold_cycles while
  // offering another character, then completes the output handshake.
  task automatic run_field(input string tag, input string s, input bit dec, input int hold_cycles);
    exp_t e = model(s, dec);
    radix_dec = dec;
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i]);
      if (i == 0) radix_dec = 1'($urandom);
    end
    check_result(tag, e);
    for (int k = 0; k < hold_cycles; k++) begin
      in_valid = 1'b1;
      in_char  = 8'h35;
      tick();
      #1;
      chk({tag, ".hold_valid"}, 64'(out_valid_a), 64'd1);
      chk({tag, ".hold_ready"}, 64'(in_ready_a), 64'd0);
      chk({tag, ".hold_num"},   64'(num_a), e.num32);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk({tag, ".released_a"}, 64'(out_valid_a), 64'd0);
    chk({tag, ".released_b"}, 64'(out_valid_b), 64'd0);
    chk({tag, ".ready_again"}, 64'(in_ready_a), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    string hexset;
    string terms;
    rst_n = 1'b0; flush = 1'b0; radix_dec = 1'b0;
    in_valid = 1'b0; in_char = 8'h00; out_ready = 1'b0;
    #1;
    chk("reset.out_valid", 64'(out_valid_a), 64'd0);
    chk("reset.in_ready",  64'(in_ready_a), 64'd1);
    chk("reset.num",       64'(num_a), 64'd0);
    chk("reset.count",     64'(dc_a), 64'd0);
    chk("reset.ovf",       64'(ovf_a), 64'd0);
    chk("reset.bad",       64'(bad_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_field("hex_7F", "7F,", 1'b0, 0);
    run_field("dec_123456", "123456*", 1'b1, 0);
    run_field("hex_ff_cr", "ff\r", 1'b0, 1);
    run_field("empty1", ",", 1'b0, 0);
    run_field("empty2", ",", 1'b1, 0);
    run_field("dec_12A", "12A", 1'b1, 0);
    run_field("empty_after_A", ",", 1'b1, 0);
    run_field("hex_1FF", "1FF,", 1'b0, 0);
    run_field("hex_05", "05,", 1'b0, 0);
    run_field("backpressure_3C", "3C,", 1'b0, 5);
    run_field("after_bp_41", "41,", 1'b0, 0);

    // async reset mid-field
    radix_dec = 1'b0;
    send_char("1");
    send_char("2");
    rst_n = 1'b0;
    #1;
    chk("midreset.num",       64'(num_a), 64'd0);
    chk("midreset.count",     64'(dc_a), 64'd0);
    chk("midreset.out_valid", 64'(out_valid_a), 64'd0);
    chk("midreset.in_ready",  64'(in_ready_a), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_field("after_reset_34", "34,", 1'b0, 0);

    // flush mid-field, with a character offered during the flush cycle
    radix_dec = 1'b0;
    send_char("9");
    flush = 1'b1; in_valid = 1'b1; in_char = 8'h35;
    #1;
    chk("flush.in_ready", 64'(in_ready_a), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    run_field("after_flush_7", "7,", 1'b0, 0);

    // flush while a result is held
    send_char("3");
    send_char(",");
    chk("flush_hold.before", 64'(out_valid_a), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_hold.out_valid", 64'(out_valid_a), 64'd0);
    chk("flush_hold.in_ready",  64'(in_ready_a), 64'd1);

    // digit_count saturation and decimal overflow
    s = "";
    for (int i = 0; i < 300; i++) s = {s, "9"};
    s = {s, ","};
    run_field("sat_300", s, 1'b1, 0);

    // randomized fields
    hexset = "0123456789abcdefABCDEF";
    terms  = ",*\r\nGx; ";
    for (int f = 0; f < 25; f++) begin
      bit dec = 1'($urandom);
      int len = $urandom_range(0, 12);
      s = "";
      for (int i = 0; i < len; i++) begin
        byte c;
        if (dec) c = 8'h30 + 8'($urandom_range(0, 9));
        else     c = hexset[$urandom_range(0, hexset.len() - 1)];
        s = {s, string'(c)};
      end
      s = {s, string'(terms[$urandom_range(0, terms.len() - 1)])};
      run_field($sformatf("rand%0d", f), s, dec, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
